sw_scan_sched: RTL

//  Debounces and edge-detects N user switches using one shared compare/debounce engine.
//  A scan tick starts one sweep that visits channels 0..N-1, one per clock, round-robin.
//  Per channel: press pulse and toggling LED state. Sits between board switch pins and LED pins.

---
 rtl/sw_scan_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sw_scan_sched.sv
// Debounces N switches with one shared engine that sweeps channels 0..N-1 per scan tick.
// Press/LED update one clk after the channel's visit; free-running, no backpressure.
module sw_scan_sched #(
    parameter int N          = 4,
    parameter int DIV_RATIO  = 16,
    parameter int STABLE_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         led_clr,
    input  logic [N-1:0] sw,
    output logic [N-1:0] led,
    output logic [N-1:0] press,
    output logic         scan_done,
    output logic         overrun
);

    localparam int DW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(STABLE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(N - 1);
    localparam logic [KW-1:0] CNT_LAST = KW'(STABLE_CNT - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sw_meta_q, sw_s_q;
    logic [DW-1:0]  div_q, div_d;
    logic           tick_q, tick_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [N-1:0]   stable_q, stable_d;
    logic [KW-1:0]  cnt_q [N];
    logic [KW-1:0]  cnt_d [N];
    logic [N-1:0]   led_q, led_d;
    logic [N-1:0]   press_q, press_d;
    logic [N-1:0]   toggle;
    logic           scan_done_q, scan_done_d;
    logic           overrun_q, overrun_d;
    logic           samp;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_q) state_d = SCAN;
            SCAN:    if (ch_q == CH_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tick divider: held at zero while disabled
    always_comb begin
        tick_d = en && (div_q == DIV_LAST);
        if (!en || div_q == DIV_LAST) div_d = '0;
        else                          div_d = div_q + 1'b1;
    end

    // shared debounce engine works on the single channel selected by ch_q
    always_comb begin
        ch_d        = ch_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        press_d     = '0;
        toggle      = '0;
        scan_done_d = 1'b0;
        overrun_d   = overrun_q;
        samp        = sw_s_q[ch_q];
        if (state_q == SCAN) begin
            if (samp == stable_q[ch_q]) begin
                cnt_d[ch_q] = '0;
            end else if (cnt_q[ch_q] != CNT_LAST) begin
                cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
            end else begin
                stable_d[ch_q] = samp;
                cnt_d[ch_q]    = '0;
                if (samp) begin
                    press_d[ch_q] = 1'b1;
                    toggle[ch_q]  = 1'b1;
                end
            end
            if (tick_q) overrun_d = 1'b1;
            if (ch_q == CH_LAST) begin
                ch_d        = '0;
                scan_done_d = 1'b1;
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end else if (tick_q) begin
            ch_d = '0;
        end
        led_d = led_clr ? '0 : (led_q ^ toggle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            ch_q        <= '0;
            stable_q    <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            led_q       <= '0;
            press_q     <= '0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sw_meta_q   <= sw;
            sw_s_q      <= sw_meta_q;
            div_q       <= div_d;
            tick_q      <= tick_d;
            ch_q        <= ch_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            press_q     <= press_d;
            scan_done_q <= scan_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign led       = led_q;
    assign press     = press_q;
    assign scan_done = scan_done_q;
    assign overrun   = overrun_q;

endmodule
